// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MAX_MASTERS = 4;
    localparam int WB_ADR_W    = 32;
    localparam int WB_DAT_W    = 32;
    localparam int WB_SEL_W    = 4;
    localparam int TIMEOUT_W   = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first requester after the one-hot
// 'last' position, searching cyclically upward. Pure combinational.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] next
);

    int last_idx;
    int idx;

    always_comb begin
        last_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (last[i]) last_idx = i;
        end

        // Walk positions last+1 .. last+N (mod N); the first hit wins.
        next = '0;
        idx  = 0;
        for (int k = 1; k <= N; k++) begin
            idx = last_idx + k;
            if (idx >= N) idx = idx - N;
            if (req[idx] && (next == '0)) next[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one classic Wishbone slave among NUM_MASTERS.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_cyc,
    input  logic [NUM_MASTERS-1:0]          m_stb,
    input  logic [NUM_MASTERS-1:0]          m_we,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_mosi,
    output logic [WB_DAT_W-1:0]             m_dat_miso,
    output logic [NUM_MASTERS-1:0]          m_ack,
    output logic [NUM_MASTERS-1:0]          m_err,
    output logic                            s_cyc,
    output logic                            s_stb,
    output logic                            s_we,
    output logic [WB_SEL_W-1:0]             s_sel,
    output logic [WB_ADR_W-1:0]             s_adr,
    output logic [WB_DAT_W-1:0]             s_dat_mosi,
    input  logic [WB_DAT_W-1:0]             s_dat_miso,
    input  logic                            s_ack,
    input  logic                            s_err,
    output logic [NUM_MASTERS-1:0]          grant
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_masters
        $error("wb_arbiter_rr: NUM_MASTERS must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_arbiter_rr: TIMEOUT_CYCLES must be in 2..255");
    end

    // After reset the pointer sits on the top master so master 0 wins first.
    localparam logic [NUM_MASTERS-1:0] LAST_RESET = {1'b1, {(NUM_MASTERS-1){1'b0}}};

    state_t                 state, state_next;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [NUM_MASTERS-1:0] last_grant, last_next;
    logic [NUM_MASTERS-1:0] pick;
    logic                   busy;
    logic                   timeout_hit;
    int                     gidx;

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req  (m_cyc),
        .last (last_grant),
        .next (pick)
    );

    assign busy = (state == BUSY);

    always_comb begin
        gidx = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) gidx = i;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last_grant;
        case (state)
            IDLE: begin
                if (|m_cyc) begin
                    state_next = BUSY;
                    grant_next = pick;
                end
            end
            BUSY: begin
                // Release only when the owner drops cyc; others are locked out.
                if (!m_cyc[gidx]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    last_next  = grant;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_RESET;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_next;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog;

    assign timeout_hit = busy && (wdog == TIMEOUT_W'(TIMEOUT_CYCLES));

    // Counts stalled strobe cycles; any response, timeout or idle clears it.
    always_ff @(posedge clk) begin
        if (rst || !busy || timeout_hit || s_ack || s_err) begin
            wdog <= '0;
        end else if (s_stb) begin
            wdog <= wdog + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Slave-side requests and master-side responses are kept in separate
    // processes because the slave may close the loop combinationally.
    always_comb begin
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_sel      = '0;
        s_adr      = '0;
        s_dat_mosi = '0;
        if (busy) begin
            s_cyc      = m_cyc[gidx];
            s_stb      = m_stb[gidx] & ~timeout_hit;
            s_we       = m_we[gidx];
            s_sel      = m_sel[gidx*WB_SEL_W +: WB_SEL_W];
            s_adr      = m_adr[gidx*WB_ADR_W +: WB_ADR_W];
            s_dat_mosi = m_dat_mosi[gidx*WB_DAT_W +: WB_DAT_W];
        end
    end

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (busy) begin
            m_ack[gidx] = s_ack & m_stb[gidx] & ~timeout_hit;
            m_err[gidx] = (s_err & m_stb[gidx]) | timeout_hit;
        end
    end

    assign m_dat_miso = s_dat_miso;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr with a one-register zero-wait slave.
// Define WB_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_wb_arbiter_rr;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  m_cyc, m_stb, m_we;
    logic [4*N-1:0]  m_sel;
    logic [32*N-1:0] m_adr, m_dat_mosi;
    logic [31:0]   m_dat_miso;
    logic [N-1:0]  m_ack, m_err;
    logic          s_cyc, s_stb, s_we;
    logic [3:0]    s_sel;
    logic [31:0]   s_adr, s_dat_mosi, s_dat_miso;
    logic          s_ack, s_err;
    logic [N-1:0]  grant;

    logic          ack_en, err_en;
    logic [31:0]   slave_reg = '0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_cyc      (m_cyc),
        .m_stb      (m_stb),
        .m_we       (m_we),
        .m_sel      (m_sel),
        .m_adr      (m_adr),
        .m_dat_mosi (m_dat_mosi),
        .m_dat_miso (m_dat_miso),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .s_cyc      (s_cyc),
        .s_stb      (s_stb),
        .s_we       (s_we),
        .s_sel      (s_sel),
        .s_adr      (s_adr),
        .s_dat_mosi (s_dat_mosi),
        .s_dat_miso (s_dat_miso),
        .s_ack      (s_ack),
        .s_err      (s_err),
        .grant      (grant)
    );

    // Zero-wait slave: responds in the same cycle as a strobe.
    assign s_ack      = ack_en & s_cyc & s_stb;
    assign s_err      = err_en & s_cyc & s_stb;
    assign s_dat_miso = slave_reg;

    always_ff @(posedge clk) begin
        if (s_cyc && s_stb && s_ack && s_we) slave_reg <= s_dat_mosi;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk1();
        clk1();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [N-1:0] acc_err;
        logic         acc_stb;
        logic [7:0]   acc_idle;

        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        m_adr = '0; m_dat_mosi = '0;
        ack_en = 1'b0; err_en = 1'b0;
        clk1();
        clk1();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_ack",   32'(m_ack), 32'h0);
        chk("rst_err",   32'(m_err), 32'h0);
        rst = 1'b0;

        // Single write from master 0
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_sel = 8'h0F;
        m_adr[31:0] = 32'h10; m_dat_mosi[31:0] = 32'hDEADBEEF;
        #1;
        chk("t1_latency", 32'(grant), 32'h0);
        clk1();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_s_dat", s_dat_mosi, 32'hDEADBEEF);
        chk("t1_s_we",  32'(s_we), 32'h1);
        chk("t1_s_adr", s_adr, 32'h10);
        chk("t1_s_sel", 32'(s_sel), 32'hF);
        ack_en = 1'b1;
        #1;
        chk("t1_ack", 32'(m_ack), 32'h1);
        clk1();
        m_cyc = 2'b00; m_stb = 2'b00; ack_en = 1'b0;
        #1;
        chk("t1_cyc_drop", 32'(s_cyc), 32'h0);
        chk("t1_hold", 32'(grant), 32'h1);
        clk1();
        chk("t1_release", 32'(grant), 32'h0);
        chk("t1_readback", m_dat_miso, 32'hDEADBEEF);

        // Simultaneous requests and round-robin order
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b00; m_we = 2'b00;
        clk1();
        chk("t2_first_m0", 32'(grant), 32'h1);
        m_cyc = 2'b10;
        clk1();
        chk("t2_bubble", 32'(grant), 32'h0);
        clk1();
        chk("t2_m1", 32'(grant), 32'h2);
        m_cyc = 2'b01;
        clk1();
        chk("t2_bubble2", 32'(grant), 32'h0);
        m_cyc = 2'b11;
        clk1();
        chk("t2_back_m0", 32'(grant), 32'h1);
        m_cyc = 2'b00;
        clk1();
        chk("t2_idle", 32'(grant), 32'h0);
        m_cyc = 2'b01;
        clk1();
        chk("t2_regrant_alone", 32'(grant), 32'h1);
        m_cyc = 2'b00;
        clk1();

        // Locked three-beat sequence by master 0 while master 1 strobes
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b01;
        m_dat_mosi[31:0] = 32'h1; m_adr[63:32] = 32'h20; ack_en = 1'b1;
        #1;
        chk("t3_idle_noack", 32'(m_ack), 32'h0);
        clk1();
        chk("t3_grant", 32'(grant), 32'h1);
        chk("t3_ack_b1", 32'(m_ack), 32'h1);
        clk1();
        m_dat_mosi[31:0] = 32'h2;
        #1;
        chk("t3_reg_b1", m_dat_miso, 32'h1);
        chk("t3_ack_b2", 32'(m_ack), 32'h1);
        clk1();
        m_we = 2'b00;
        #1;
        chk("t3_lock", 32'(grant), 32'h1);
        chk("t3_read", m_dat_miso, 32'h2);
        chk("t3_ack_b3", 32'(m_ack), 32'h1);
        chk("t3_s_we", 32'(s_we), 32'h0);
        m_cyc = 2'b10; m_stb = 2'b10;
        clk1();
        chk("t3_release", 32'(grant), 32'h0);
        chk("t3_m1_wait_ack", 32'(m_ack), 32'h0);
        clk1();
        chk("t3_m1_grant", 32'(grant), 32'h2);
        chk("t3_m1_ack", 32'(m_ack), 32'h2);
        chk("t3_m1_adr", s_adr, 32'h20);

        // Error routing then reset mid-transfer
        ack_en = 1'b0;
        #1;
        chk("t4_stb", 32'(s_stb), 32'h1);
        chk("t4_stall_ack", 32'(m_ack), 32'h0);
        err_en = 1'b1;
        #1;
        chk("t4_err_route", 32'(m_err), 32'h2);
        err_en = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        rst = 1'b1;
        clk1();
        chk("t4_rst_grant", 32'(grant), 32'h0);
        chk("t4_rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("t4_rst_ack", 32'(m_ack), 32'h0);
        chk("t4_rst_err", 32'(m_err), 32'h0);
        rst = 1'b0;
        clk1();
        chk("t4_post_m0", 32'(grant), 32'h1);
        m_cyc = 2'b00; m_stb = 2'b00;
        clk1();
        chk("t4_idle", 32'(grant), 32'h0);

        // Stalled slave
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; ack_en = 1'b0;
        clk1();
        chk("t5_grant", 32'(grant), 32'h1);
        acc_err = '0;
        acc_stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            acc_err = acc_err | m_err;
            acc_stb = acc_stb & s_stb;
            clk1();
        end
        chk("t5_no_early_err", 32'(acc_err), 32'h0);
        chk("t5_stb_before", 32'(acc_stb), 32'h1);
        chk("t5_err_pulse", 32'(m_err), 32'h1);
        chk("t5_stb_forced", 32'(s_stb), 32'h0);
        clk1();
        chk("t5_err_single", 32'(m_err), 32'h0);
        chk("t5_stb_again", 32'(s_stb), 32'h1);
        chk("t5_hold", 32'(grant), 32'h1);
`else
        for (int k = 0; k < 40; k++) begin
            acc_err = acc_err | m_err;
            acc_stb = acc_stb & s_stb;
            clk1();
        end
        chk("t5_no_err", 32'(acc_err), 32'h0);
        chk("t5_stb_held", 32'(acc_stb), 32'h1);
        chk("t5_hold", 32'(grant), 32'h1);
`endif
        m_cyc = 2'b00; m_stb = 2'b00;
        clk1();
        chk("t5_release", 32'(grant), 32'h0);

        // Long idle stretch
        acc_idle = '0;
        ack_en = 1'b1; err_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            clk1();
            acc_idle = acc_idle | {1'b0, grant, s_cyc, m_ack, m_err};
        end
        chk("t6_idle_quiet", 32'(acc_idle), 32'h0);
        ack_en = 1'b0; err_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
